mult_result_serializer: RTL and testbench
=========================================

Name: mult_result_serializer

Overview:
- Downstream stage of the 3-cycle pipelined 8x8 multiplier.
- Tracks which multiplier issues carry valid operands and captures each 16-bit product when it emerges LAT cycles later.
- Buffers products in a small FIFO and streams each one out over the chip's 8-bit output bus as two bytes, low byte first, using a valid/ready handshake.
- Supplies credit-based backpressure (issue_ready) so upstream never issues more products than can be buffered.

Parameters:
- LAT, 3, fixed multiplier latency in cycles from issue to product on prod.
- DEPTH, 4, result FIFO entries; must be a power of 2, 2..16.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- issue  input  1  pulse: operands were presented to the multiplier this cycle.
- issue_ready  output  1  upstream may assert issue this cycle.
- prod  input  16  multiplier product output.
- out_data  output  8  current byte of the head product.
- out_hi  output  1  0 = low byte on out_data, 1 = high byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte this cycle.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset: asynchronous, active-high; clock is clk.
- Reset values: valid pipeline cleared, FIFO empty, phase = LO, overflow = 0.
- Reset output state: out_valid = 0, out_hi = 0, out_data = 0, issue_ready = 1.
- Reset mid-operation discards all in-flight and buffered products; no partial byte pairs survive reset.
- Issue tracking:
  - LAT-bit shift register vpipe; stage 0 loads the accepted issue each cycle.
  - An issue is accepted only when issue_ready = 1.
  - When vpipe[LAT-1] = 1, prod is written into the FIFO on that clock edge.
  - Issue at edge N means the product is captured at edge N+LAT.
- Credit:
  - issue_ready = (popcount(vpipe) + occ) < DEPTH, using registered values only.
  - A FIFO pop in the current cycle does not raise issue_ready until the next cycle.
  - issue asserted while issue_ready = 0 is dropped (not tracked) and sets overflow.
  - If a capture would arrive with the FIFO full (unreachable when credit is obeyed), the product is dropped and overflow is set.
  - overflow clears only on reset.
- FIFO:
  - Registered head/tail pointers and an occupancy count occ, 0..DEPTH.
  - Push and pop in the same cycle are both performed; occ is unchanged.
  - Pointers wrap modulo DEPTH.
- Output state machine:
  - Two states, LO and HI, held in a phase register.
  - out_valid = (occ != 0); out_hi = (phase == HI).
  - out_data = head[7:0] in LO, head[15:8] in HI; out_data = 0 when empty.
  - LO with out_valid & out_ready -> HI, no pop.
  - HI with out_valid & out_ready -> pop the head and return to LO.
  - No handshake -> hold state; out_data and out_hi must stay stable while out_valid = 1 and out_ready = 0.
  - A product pushed into an empty FIFO appears on out_data the cycle after the capture edge (registered FIFO, no bypass).
- Throughput: one product per 2 cycles at the output with out_ready held high. A sustained issue rate above 1/2 throttles via issue_ready.

Test Plan:
- Single product: reset, issue once with A=13, B=11 through the real multiplier. Expect out_valid to rise LAT+1 cycles after the issue edge, then bytes 0x8F (out_hi = 0) and 0x00 (out_hi = 1), then out_valid = 0.
- Max value: A=255, B=255 -> bytes 0x01 then 0xFE; overflow stays 0.
- Backpressure hold: out_ready = 0 for 5 cycles with product 0x1234 buffered. Expect out_data = 0x34, out_hi = 0 held stable; then out_ready = 1 -> 0x34, then 0x12.
- Credit limit: issue every cycle with out_ready = 0. Expect exactly DEPTH = 4 issues accepted, issue_ready low afterwards, overflow = 0. Release out_ready -> 4 products drained in issue order (8 bytes); issue_ready rises the cycle after the first pop.
- Illegal issue: assert issue while issue_ready = 0. Expect overflow = 1 (sticky), FIFO contents unchanged, dropped product never output.
- Reset mid-stream: assert reset while in HI with 2 products buffered and 1 in flight. Expect outputs at reset values immediately. After deassertion, no stale bytes appear and a new issue of 3x5 yields bytes 0x0F, 0x00.

Source files
------------

// File: rtl/mult_result_serializer.sv
// Captures products from the 3-cycle multiplier, buffers them in a small FIFO and
// streams each one out as two bytes (low first) with credit-based issue backpressure.
module mult_result_serializer #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    output logic        issue_ready,
    input  logic [15:0] prod,
    output logic [7:0]  out_data,
    output logic        out_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(LAT + DEPTH + 1);

    typedef enum logic {StLo, StHi} phase_e;

    logic [LAT-1:0] vpipe_q, vpipe_d;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  occ_q, occ_d;
    phase_e         phase_q, phase_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    mem_q [DEPTH];

    logic [SW-1:0]  credit_used;
    logic           issue_acc, capture, full, push, pop, handshake;
    logic [15:0]    head_word;

    // Credit counts both in-flight issues and buffered products, registered state only.
    always_comb begin
        credit_used = SW'(occ_q);
        for (int i = 0; i < LAT; i++) begin
            credit_used = credit_used + SW'(vpipe_q[i]);
        end
    end

    assign issue_ready = (credit_used < SW'(DEPTH));
    assign issue_acc   = issue & issue_ready;
    assign capture     = vpipe_q[LAT-1];
    assign full        = (occ_q == CW'(DEPTH));
    assign push        = capture & ~full;

    assign out_valid = (occ_q != '0);
    assign out_hi    = (phase_q == StHi);
    assign head_word = mem_q[head_q];
    assign handshake = out_valid & out_ready;
    assign pop       = handshake & (phase_q == StHi);

    always_comb begin
        out_data = 8'h00;
        if (out_valid) begin
            out_data = out_hi ? head_word[15:8] : head_word[7:0];
        end
    end

    always_comb begin
        vpipe_d    = {vpipe_q[LAT-2:0], issue_acc};
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
        // Dropped issue or dropped capture both latch the error until reset.
        if ((issue & ~issue_ready) | (capture & full)) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            StLo:    if (handshake) phase_d = StHi;
            StHi:    if (handshake) phase_d = StLo;
            default: phase_d = StLo;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            phase_q    <= StLo;
            overflow_q <= 1'b0;
        end else begin
            vpipe_q    <= vpipe_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= prod;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_result_serializer.sv
// Directed bench: a 3-stage multiplier model feeds the serializer; each task checks
// one scenario inline against hand-computed bytes.
module tb_mult_result_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue;
    logic        issue_ready;
    logic [15:0] prod;
    logic [7:0]  out_data;
    logic        out_hi;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    logic [7:0]  a, b;
    logic [15:0] m1, m2, m3;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Multiplier model: product of operands sampled at edge N is on prod before edge N+3.
    always @(posedge clk) begin
        m1 <= a * b;
        m2 <= m1;
        m3 <= m2;
    end
    assign prod = m3;

    mult_result_serializer #(.LAT(3), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_ready(issue_ready),
        .prod       (prod),
        .out_data   (out_data),
        .out_hi     (out_hi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow)
    );

    task automatic test_reset;
        reset = 1'b1; issue = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_hi !== 1'b0) begin n_fail++; $display("FAIL reset_hi: got %b expected 0", out_hi); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        @(negedge clk); issue = 1'b1; a = 8'd13; b = 8'd11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); issue = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid k=%0d: got %b expected 0", k, out_valid); end
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got valid %b expected 1", out_valid); end
        n_cmp++; if ({out_hi, out_data} !== {1'b0, 8'h8F}) begin n_fail++; $display("FAIL single_lo: got hi=%b data=%h expected hi=0 data=8f", out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL single_hi: got v=%b hi=%b data=%h expected v=1 hi=1 data=00", out_valid, out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_max;
        int waited;
        out_ready = 1'b1;
        @(negedge clk); issue = 1'b1; a = 8'd255; b = 8'd255;
        @(negedge clk); issue = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL max_timeout: got valid %b expected 1", out_valid); end
        n_cmp++; if ({out_hi, out_data} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL max_lo: got hi=%b data=%h expected hi=0 data=01", out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if ({out_hi, out_data} !== {1'b1, 8'hFE}) begin n_fail++; $display("FAIL max_hi: got hi=%b data=%h expected hi=1 data=fe", out_hi, out_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL max_overflow: got %b expected 0", overflow); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int waited;
        out_ready = 1'b0;
        @(negedge clk); issue = 1'b1; a = 8'd233; b = 8'd20;   // 0x1234
        @(negedge clk); issue = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got valid %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b10, 8'h34}) begin n_fail++; $display("FAIL bp_hold i=%0d: got v=%b hi=%b data=%h expected v=1 hi=0 data=34", i, out_valid, out_hi, out_data); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_cmp++; if ({out_hi, out_data} !== {1'b0, 8'h34}) begin n_fail++; $display("FAIL bp_lo: got hi=%b data=%h expected hi=0 data=34", out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if ({out_hi, out_data} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL bp_hi: got hi=%b data=%h expected hi=1 data=12", out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_credit_limit;
        int accepted;
        logic [15:0] exp_p;
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue = issue_ready;
            a = 8'(accepted + 1); b = 8'(accepted + 2);
            if (issue_ready) accepted++;
        end
        @(negedge clk); issue = 1'b0;
        n_cmp++; if (accepted != 4) begin n_fail++; $display("FAIL credit_accepted: got %0d expected 4", accepted); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready_low: got %b expected 0", issue_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL credit_overflow: got %b expected 0", overflow); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_p = 16'((j + 1) * (j + 2));
            if (j == 0) begin
                n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready_prepop: got %b expected 0", issue_ready); end
            end
            if (j == 1) begin
                n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL credit_ready_postpop: got %b expected 1", issue_ready); end
            end
            n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b10, exp_p[7:0]}) begin n_fail++; $display("FAIL credit_lo j=%0d: got v=%b hi=%b data=%h expected v=1 hi=0 data=%h", j, out_valid, out_hi, out_data, exp_p[7:0]); end
            @(negedge clk);
            if (j == 0) begin
                n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready_popcycle: got %b expected 0", issue_ready); end
            end
            n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b11, exp_p[15:8]}) begin n_fail++; $display("FAIL credit_hi j=%0d: got v=%b hi=%b data=%h expected v=1 hi=1 data=%h", j, out_valid, out_hi, out_data, exp_p[15:8]); end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL credit_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal_issue;
        int accepted;
        logic [15:0] exp_p;
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue = issue_ready;
            a = 8'(200 + accepted); b = 8'd7;
            if (issue_ready) accepted++;
        end
        @(negedge clk); issue = 1'b0;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_ready: got %b expected 0", issue_ready); end
        issue = 1'b1; a = 8'd99; b = 8'd99;
        @(negedge clk); issue = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL illegal_overflow: got %b expected 1", overflow); end
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_p = 16'((200 + j) * 7);
            n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b10, exp_p[7:0]}) begin n_fail++; $display("FAIL illegal_lo j=%0d: got v=%b hi=%b data=%h expected v=1 hi=0 data=%h", j, out_valid, out_hi, out_data, exp_p[7:0]); end
            @(negedge clk);
            n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b11, exp_p[15:8]}) begin n_fail++; $display("FAIL illegal_hi j=%0d: got v=%b hi=%b data=%h expected v=1 hi=1 data=%h", j, out_valid, out_hi, out_data, exp_p[15:8]); end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_dropped k=%0d: got valid %b expected 0", k, out_valid); end
            @(negedge clk);
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid_stream;
        int waited;
        out_ready = 1'b0;
        @(negedge clk); issue = 1'b1; a = 8'd17; b = 8'd19;
        @(negedge clk); a = 8'd21; b = 8'd23;
        @(negedge clk); issue = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1; issue = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk); out_ready = 1'b0; issue = 1'b0;
        n_cmp++; if ({out_valid, out_hi} !== 2'b11) begin n_fail++; $display("FAIL mid_setup: got v=%b hi=%b expected v=1 hi=1", out_valid, out_hi); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b00, 8'h00}) begin n_fail++; $display("FAIL mid_reset_out: got v=%b hi=%b data=%h expected v=0 hi=0 data=00", out_valid, out_hi, out_data); end
        n_cmp++; if ({issue_ready, overflow} !== 2'b10) begin n_fail++; $display("FAIL mid_reset_flags: got ready=%b ovf=%b expected ready=1 ovf=0", issue_ready, overflow); end
        @(negedge clk); reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale k=%0d: got valid %b expected 0", k, out_valid); end
        end
        issue = 1'b1; a = 8'd3; b = 8'd5;
        @(negedge clk); issue = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b10, 8'h0F}) begin n_fail++; $display("FAIL mid_new_lo: got v=%b hi=%b data=%h expected v=1 hi=0 data=0f", out_valid, out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if ({out_valid, out_hi, out_data} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL mid_new_hi: got v=%b hi=%b data=%h expected v=1 hi=1 data=00", out_valid, out_hi, out_data); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_new_empty: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_backpressure();
        test_credit_limit();
        test_illegal_issue();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
